// File: rtl/vga_timing_detector_if.sv
// Sync/blank stream into the timing detector and the recovered counters and status out of it.
// The master modport is the stream source side; the slave modport is the detector.
interface vga_timing_detector_if;
    logic        hsync_in;
    logic        vsync_in;
    logic        hblnk_in;
    logic        vblnk_in;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic [10:0] line_len;
    logic [10:0] frame_lines;
    logic        locked;
    logic        sync_err;

    modport master (
        output hsync_in, vsync_in, hblnk_in, vblnk_in,
        input  hsync_out, vsync_out, hblnk_out, vblnk_out,
        input  hcount, vcount, line_len, frame_lines, locked, sync_err
    );

    modport slave (
        input  hsync_in, vsync_in, hblnk_in, vblnk_in,
        output hsync_out, vsync_out, hblnk_out, vblnk_out,
        output hcount, vcount, line_len, frame_lines, locked, sync_err
    );
endinterface

// File: rtl/vga_timing_detector.sv
// Rebuilds hcount/vcount from an incoming sync/blank stream, measures line and frame length
// and tracks lock against the expected geometry with a SEARCH/ACQUIRE/LOCKED machine.
module vga_timing_detector #(
    parameter int unsigned H_TOT       = 1344,
    parameter int unsigned V_TOT       = 806,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    vga_timing_detector_if.slave bus
);
    localparam logic [11:0] HTot       = 12'(H_TOT);
    localparam logic [11:0] VTot       = 12'(V_TOT);
    localparam logic [4:0]  LockFrames = 5'(LOCK_FRAMES);
    localparam logic [10:0] CntMax     = 11'h7ff;

    typedef enum logic [1:0] {StSearch, StAcquire, StLocked} state_e;

    state_e      state_q, state_d;
    logic [3:0]  s1_q, s2_q; // {hsync, vsync, hblnk, vblnk}
    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic [10:0] line_len_q, line_len_d;
    logic [10:0] frame_lines_q, frame_lines_d;
    logic        h_seen_q, h_seen_d;
    logic        v_seen_q, v_seen_d;
    logic        frame_ok_q, frame_ok_d;
    logic        sync_err_q, sync_err_d;
    logic [3:0]  good_cnt_q, good_cnt_d;

    logic        line_start, frame_start, line_bad, frame_bad, saturated;
    logic [11:0] h_len, v_len;

    assign line_start  = s2_q[1] & ~s1_q[1];
    assign frame_start = line_start & s2_q[0] & ~s1_q[0];
    assign h_len       = {1'b0, hcount_q} + 12'd1;
    assign v_len       = {1'b0, vcount_q} + 12'd1;
    assign saturated   = (hcount_q == CntMax) | (vcount_q == CntMax);
    assign line_bad    = line_start & h_seen_q & (h_len != HTot);
    // The line ending at a frame start counts toward the frame it closes.
    assign frame_bad   = frame_start & v_seen_q & ~(frame_ok_q & ~line_bad & (v_len == VTot));

    always_comb begin
        state_d       = state_q;
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        h_seen_d      = h_seen_q;
        v_seen_d      = v_seen_q;
        frame_ok_d    = frame_ok_q;
        good_cnt_d    = good_cnt_q;
        sync_err_d    = 1'b0;

        if (line_start) begin
            hcount_d = '0;
            if (h_seen_q) line_len_d = h_len[10:0];
            h_seen_d = 1'b1;
        end else if (hcount_q != CntMax) begin
            hcount_d = hcount_q + 11'd1;
        end

        if (frame_start) begin
            vcount_d   = '0;
            if (v_seen_q) frame_lines_d = v_len[10:0];
            v_seen_d   = 1'b1;
            frame_ok_d = 1'b1;
        end else begin
            if (line_start && vcount_q != CntMax) vcount_d = vcount_q + 11'd1;
            if (line_bad) frame_ok_d = 1'b0;
        end

        case (state_q)
            StSearch: begin
                if (frame_start) begin
                    state_d    = StAcquire;
                    good_cnt_d = '0;
                end
            end
            StAcquire: begin
                if (line_bad || frame_bad) begin
                    sync_err_d = 1'b1;
                    good_cnt_d = '0;
                end else if (frame_start && v_seen_q) begin
                    good_cnt_d = good_cnt_q + 4'd1;
                    if ({1'b0, good_cnt_d} >= LockFrames) state_d = StLocked;
                end
            end
            StLocked: begin
                if (line_bad || frame_bad || saturated) begin
                    sync_err_d = 1'b1;
                    state_d    = StSearch;
                    h_seen_d   = 1'b0;
                    v_seen_d   = 1'b0;
                end
            end
            default: state_d = StSearch;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StSearch;
            s1_q          <= '0;
            s2_q          <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            h_seen_q      <= 1'b0;
            v_seen_q      <= 1'b0;
            frame_ok_q    <= 1'b0;
            sync_err_q    <= 1'b0;
            good_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            s1_q          <= {bus.hsync_in, bus.vsync_in, bus.hblnk_in, bus.vblnk_in};
            s2_q          <= s1_q;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            h_seen_q      <= h_seen_d;
            v_seen_q      <= v_seen_d;
            frame_ok_q    <= frame_ok_d;
            sync_err_q    <= sync_err_d;
            good_cnt_q    <= good_cnt_d;
        end
    end

    assign bus.hsync_out   = s2_q[3];
    assign bus.vsync_out   = s2_q[2];
    assign bus.hblnk_out   = s2_q[1];
    assign bus.vblnk_out   = s2_q[0];
    assign bus.hcount      = hcount_q;
    assign bus.vcount      = vcount_q;
    assign bus.line_len    = line_len_q;
    assign bus.frame_lines = frame_lines_q;
    assign bus.locked      = (state_q == StLocked);
    assign bus.sync_err    = sync_err_q;
endmodule
